serial_add_sub: RTL

Multi-cycle, parametrised two's-complement adder/subtractor that processes `CHUNK` bits per clock and uses a registered carry between chunks. It generalises the ripple-carry adder to arbitrary `WIDTH` and adds subtract mode, a start/busy/done handshake and registered result flags. It sits between switch/register inputs and the display or ALU datapath wherever area matters more than single-cycle latency.

---
 rtl/serial_add_sub_pkg.sv | 33 +++
 rtl/serial_add_sub_chunk_adder.sv | 29 ++
 rtl/serial_add_sub.sv | 108 ++++++++++
 3 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder/subtractor.
package adder_pkg;

    // Sequencer states: waiting, stepping through chunks, result just produced
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Chunk index width; a single-chunk build still needs a one-bit index
    function automatic int idxWidth(input int numChunks);
        return (clog2(numChunks) < 1) ? 1 : clog2(numChunks);
    endfunction

    // Legal parameter combinations: WIDTH >= 2, CHUNK >= 1, CHUNK divides WIDTH
    function automatic bit chunkingValid(input int width, input int chunk);
        return (width >= 2) && (chunk >= 1) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/serial_add_sub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder used for one slice per clock.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] carryChain;

    assign carryChain[0] = cin;

    // Ripple chain of full-adder cells, one per bit of the slice
    for (genvar i = 0; i < CHUNK; i++) begin : fullAdder
        assign s[i]              = a[i] ^ b[i] ^ carryChain[i];
        assign carryChain[i + 1] = (a[i] & b[i]) | (carryChain[i] & (a[i] ^ b[i]));
    end

    // The carry into the top bit is what the signed-overflow flag needs
    assign cout     = carryChain[CHUNK];
    assign c_msb_in = carryChain[CHUNK-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock with a
// registered carry between slices and a start/busy/done handshake.
module serial_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             over
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = idxWidth(N);
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    if (!chunkingValid(WIDTH, CHUNK)) begin : badParams
        $error("serial_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] chunkA;
    logic [CHUNK-1:0] chunkB;
    logic [CHUNK-1:0] chunkSum;
    logic             chunkCout;
    logic             chunkMsbIn;

    assign chunkA = opA[int'(idx) * CHUNK +: CHUNK];
    assign chunkB = opB[int'(idx) * CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) sliceAdder (
        .a        (chunkA),
        .b        (chunkB),
        .cin      (carry),
        .s        (chunkSum),
        .cout     (chunkCout),
        .c_msb_in (chunkMsbIn)
    );

    // Sequencer: accept operands when not busy, add one slice per edge, flag the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            over  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            opA   <= '0;
            opB   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opA   <= a;
                        opB   <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        over  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[int'(idx) * CHUNK +: CHUNK] <= chunkSum;
                    carry <= chunkCout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout  <= chunkCout;
                        over  <= chunkMsbIn ^ chunkCout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
